// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the dual-port byte-lane memory.
package mem_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return delay line for one port: valid/data emerge RD_LAT cycles after issue.
// Data holds its last value whenever valid is low.
module mem_rd_pipe #(
    parameter int DATA_W = 24,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;

    always_comb begin
        s1_valid_d = in_valid;
        s1_data_d  = in_valid ? in_data : s1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid_q, s2_valid_d;
            logic [DATA_W-1:0] s2_data_q, s2_data_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign out_valid = s2_valid_q;
            assign out_data  = s2_data_q;
        end else begin : g_lat1
            assign out_valid = s1_valid_q;
            assign out_data  = s1_data_q;
        end
    endgenerate

endmodule

// File: rtl/mem_dp.sv
// True dual-port memory with byte-lane writes, write-first/cross-port forwarding,
// port-0-wins collisions and an optional post-reset zeroing sweep.
`ifndef MEM_HEX_FILE
`define MEM_HEX_FILE "mem_init.hex"
`endif

module mem_dp import mem_pkg::*; #(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1,
    parameter int READ_MEM     = 0
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_en    [0:1],
    input  logic              iw_we    [0:1],
    input  logic [DATA_W/8-1:0] iw_be  [0:1],
    input  logic [ADDR_W-1:0] iw_addr  [0:1],
    input  logic [DATA_W-1:0] iw_wdata [0:1],
    output logic [DATA_W-1:0] or_rdata [0:1],
    output logic              or_rvalid [0:1],
    output logic              or_ready
);

    localparam int     NB        = DATA_W / 8;
    localparam int     DEPTH     = 2 ** ADDR_W;
    localparam state_e RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : READY;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              ready_q, ready_d;

    logic              acc  [0:1];
    logic              wr   [0:1];
    logic [DATA_W-1:0] post [0:1];
    logic              clear_we;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_W{1'b1}}) state_d = READY;
            end
            READY: state_d = READY;
        endcase
        ready_d = (state_d == READY);
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    // Each port sees the word as it will be after this cycle's writes; port 0 overrides port 1 per lane.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p] = ready_q & iw_en[p];
            wr[p]  = ready_q & iw_en[p] & iw_we[p];
        end
        for (int p = 0; p < 2; p++) begin
            post[p] = mem[iw_addr[p]];
            for (int b = 0; b < NB; b++) begin
                if (wr[0] && iw_addr[0] == iw_addr[p] && iw_be[0][b])
                    post[p][8*b +: 8] = iw_wdata[0][8*b +: 8];
                else if (wr[1] && iw_addr[1] == iw_addr[p] && iw_be[1][b])
                    post[p][8*b +: 8] = iw_wdata[1][8*b +: 8];
            end
        end
        clear_we = (state_q == CLEAR) && !iw_rst;
    end

    always_ff @(posedge iw_clk) begin
        if (clear_we) mem[clr_addr_q] <= '0;
        for (int p = 0; p < 2; p++) begin
            if (wr[p]) mem[iw_addr[p]] <= post[p];
        end
    end

    assign or_ready = ready_q;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            mem_rd_pipe #(
                .DATA_W (DATA_W),
                .RD_LAT (RD_LAT)
            ) u_rd_pipe (
                .clk       (iw_clk),
                .rst       (iw_rst),
                .in_valid  (acc[p]),
                .in_data   (post[p]),
                .out_valid (or_rvalid[p]),
                .out_data  (or_rdata[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mem_dp.sv
// Self-checking bench for mem_dp (ADDR_W=4, RD_LAT=2, clear-on-reset) against a
// behavioural word/lane model with a per-cycle expected-return schedule.
module tb_mem_dp;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en    [0:1];
    logic          we    [0:1];
    logic [NB-1:0] be    [0:1];
    logic [AW-1:0] addr  [0:1];
    logic [DW-1:0] wdata [0:1];
    logic [DW-1:0] rdata [0:1];
    logic          rvalid [0:1];
    logic          ready;

    logic [DW-1:0] model_mem [0:DEPTH-1];
    logic          sched_v [0:1][0:7];
    logic [DW-1:0] sched_d [0:1][0:7];
    logic [DW-1:0] last_d  [0:1];
    int            cyc;
    int            clear_left;
    int            checks;
    int            errors;

    always #5 clk = ~clk;

    mem_dp #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .RD_LAT       (LAT),
        .CLEAR_ON_RST (1),
        .READ_MEM     (0)
    ) dut (
        .iw_clk    (clk),
        .iw_rst    (rst),
        .iw_en     (en),
        .iw_we     (we),
        .iw_be     (be),
        .iw_addr   (addr),
        .iw_wdata  (wdata),
        .or_rdata  (rdata),
        .or_rvalid (rvalid),
        .or_ready  (ready)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            en[p]    = 1'b0;
            we[p]    = 1'b0;
            be[p]    = '0;
            addr[p]  = '0;
            wdata[p] = '0;
        end
    endtask

    task automatic apply_stimulus(input int p, input logic e, input logic w, input logic [NB-1:0] b,
                                  input logic [AW-1:0] a, input logic [DW-1:0] d);
        en[p]    = e;
        we[p]    = w;
        be[p]    = b;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] lanes);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++)
            if (lanes[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Word at address a once this cycle's writes land: port 1 applied first, port 0 on top.
    function automatic logic [DW-1:0] post_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = model_mem[a];
        if (en[1] && we[1] && addr[1] == a) w = merge(w, wdata[1], be[1]);
        if (en[0] && we[0] && addr[0] == a) w = merge(w, wdata[0], be[0]);
        return w;
    endfunction

    task automatic flush_model();
        for (int p = 0; p < 2; p++) begin
            last_d[p] = '0;
            for (int s = 0; s < 8; s++) begin
                sched_v[p][s] = 1'b0;
                sched_d[p][s] = '0;
            end
        end
    endtask

    task automatic do_cycle();
        logic          accept;
        logic [DW-1:0] res [0:1];
        int            slot;
        accept = (clear_left == 0) && !rst;
        slot   = (cyc + LAT) % 8;
        if (accept) begin
            for (int p = 0; p < 2; p++) res[p] = post_word(addr[p]);
            for (int p = 0; p < 2; p++) begin
                if (en[p]) begin
                    sched_v[p][slot] = 1'b1;
                    sched_d[p][slot] = res[p];
                end
            end
            for (int p = 0; p < 2; p++)
                if (en[p] && we[p]) model_mem[addr[p]] = res[p];
        end
        @(posedge clk);
        cyc++;
        if (clear_left > 0) clear_left--;
        @(negedge clk);
        slot = cyc % 8;
        for (int p = 0; p < 2; p++) begin
            if (sched_v[p][slot]) last_d[p] = sched_d[p][slot];
            check_output($sformatf("rvalid%0d@%0d", p, cyc), 32'(rvalid[p]), 32'(sched_v[p][slot]));
            check_output($sformatf("rdata%0d@%0d", p, cyc), 32'(rdata[p]), 32'(last_d[p]));
            sched_v[p][slot] = 1'b0;
        end
        check_output($sformatf("ready@%0d", cyc), 32'(ready), 32'(clear_left == 0));
        idle();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        for (int p = 0; p < 2; p++) begin
            check_output($sformatf("rst_rvalid%0d", p), 32'(rvalid[p]), 32'd0);
            check_output($sformatf("rst_rdata%0d", p), 32'(rdata[p]), 32'd0);
        end
        check_output("rst_ready", 32'(ready), 32'd0);
        flush_model();
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        clear_left = DEPTH;
        idle();
        flush_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        @(negedge clk);
        apply_reset();
        repeat (DEPTH) do_cycle();

        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(0, 1'b1, 1'b0, '0, AW'(i), '0);
            apply_stimulus(1, 1'b1, 1'b0, '0, AW'(DEPTH - 1 - i), '0);
            do_cycle();
        end
        repeat (3) do_cycle();

        apply_stimulus(0, 1'b1, 1'b1, 3'b111, 4'd5, 24'hAABBCC);
        do_cycle();
        apply_stimulus(0, 1'b1, 1'b1, 3'b010, 4'd5, 24'h112233);
        do_cycle();
        apply_stimulus(1, 1'b1, 1'b0, 3'b000, 4'd5, '0);
        do_cycle();
        repeat (2) do_cycle();
        check_output("byte_lane_rd", 32'(rdata[1]), 32'h00AA22CC);

        apply_stimulus(0, 1'b1, 1'b1, 3'b001, 4'd7, 24'h000011);
        apply_stimulus(1, 1'b1, 1'b1, 3'b011, 4'd7, 24'h223344);
        do_cycle();
        apply_stimulus(0, 1'b1, 1'b0, 3'b000, 4'd7, '0);
        apply_stimulus(1, 1'b1, 1'b0, 3'b000, 4'd7, '0);
        do_cycle();
        repeat (2) do_cycle();
        check_output("collide_rd0", 32'(rdata[0]), 32'h00003311);
        check_output("collide_rd1", 32'(rdata[1]), 32'h00003311);

        apply_stimulus(1, 1'b1, 1'b1, 3'b111, 4'd9, 24'h5A5A5A);
        apply_stimulus(0, 1'b1, 1'b0, 3'b000, 4'd9, '0);
        do_cycle();
        do_cycle();
        check_output("fwd_rvalid0", 32'(rvalid[0]), 32'd1);
        check_output("fwd_rdata0", 32'(rdata[0]), 32'h005A5A5A);

        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(0, 1'b1, 1'b1, 3'b111, AW'(i), DW'($urandom()));
            do_cycle();
        end
        repeat (2) do_cycle();
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(0, 1'b1, 1'b0, 3'b000, AW'(i), '0);
            do_cycle();
        end
        repeat (3) do_cycle();

        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < 2; p++) begin
                apply_stimulus(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               NB'($urandom_range(0, 7)),
                               ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3))
                                                           : AW'($urandom_range(0, DEPTH - 1)),
                               DW'($urandom()));
            end
            do_cycle();
        end
        repeat (3) do_cycle();

        apply_stimulus(0, 1'b1, 1'b0, 3'b000, 4'd2, '0);
        do_cycle();
        apply_reset();
        repeat (DEPTH + 4) do_cycle();

        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(0, 1'b1, 1'b0, '0, AW'(i), '0);
            do_cycle();
        end
        repeat (3) do_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
